// File: rtl/operand_bank_pkg.sv
// operand_bank_pkg
//   Shared definitions for the operand bank: FSM state encoding and the
//   width helpers used to size the dimension ports and address counters.
//   No ports; imported by operand_bank_if, operand_bank_ram and operand_bank.
package operand_bank_pkg;

  // Controller states, fixed encodings so waveforms read the same everywhere
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_X = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Width of a dimension value 0..dimMax
  function automatic int dimWidth(input int dimMax);
    return $clog2(dimMax + 1);
  endfunction

  // Width of a flat element index 0..dimMax*dimMax-1
  function automatic int cntWidth(input int dimMax);
    return $clog2(dimMax * dimMax);
  endfunction

endpackage

// File: rtl/operand_bank_if.sv
// operand_bank_if
//   Bundles the operand bank's control, load and stream signals.
//   master: drives start/dims/in_valid/in_data (and mac_ready when the
//           OPERAND_BANK_BACKPRESSURE_EN macro is defined), observes the rest.
//   slave : the operand bank itself.
//   Signals: start, row_w, col_w, col_x, in_valid, in_data, in_ready,
//            data_outw, data_outx, out_valid, ld_mac, clear_mac,
//            unload_res, busy, err [, mac_ready].
interface operand_bank_if
  import operand_bank_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int DIM_MAX = 3
) ();

  localparam int DIM_W = dimWidth(DIM_MAX);

  logic                        start;
  logic [DIM_W-1:0]            row_w;
  logic [DIM_W-1:0]            col_w;
  logic [DIM_W-1:0]            col_x;
  logic                        in_valid;
  logic [DATA_W-1:0]           in_data;
  logic                        in_ready;
  logic [DIM_MAX*DATA_W-1:0]   data_outw;
  logic [DIM_MAX*DATA_W-1:0]   data_outx;
  logic                        out_valid;
  logic [DIM_MAX*DIM_MAX-1:0]  ld_mac;
  logic [DIM_MAX*DIM_MAX-1:0]  clear_mac;
  logic                        unload_res;
  logic                        busy;
  logic                        err;
`ifdef OPERAND_BANK_BACKPRESSURE_EN
  logic                        mac_ready;
`endif

  modport master (
`ifdef OPERAND_BANK_BACKPRESSURE_EN
    output mac_ready,
`endif
    output start, row_w, col_w, col_x, in_valid, in_data,
    input  in_ready, data_outw, data_outx, out_valid, ld_mac, clear_mac,
           unload_res, busy, err
  );

  modport slave (
`ifdef OPERAND_BANK_BACKPRESSURE_EN
    input  mac_ready,
`endif
    input  start, row_w, col_w, col_x, in_valid, in_data,
    output in_ready, data_outw, data_outx, out_valid, ld_mac, clear_mac,
           unload_res, busy, err
  );

endinterface

// File: rtl/operand_bank_ram.sv
// operand_bank_ram
//   DIM_MAX*DIM_MAX x DATA_W register file holding one operand matrix.
//   One synchronous write port, DIM_MAX combinational read lanes.
//   Lane l reads address base_i + l*stride_i; lanes with l >= count_i read 0.
//   Ports:
//     clk       clock, rising edge
//     we_i      write enable
//     waddr_i   write address (flat row-major index)
//     wdata_i   write data
//     base_i    read address of lane 0
//     stride_i  address step between lanes
//     count_i   number of active lanes
//     rdata_o   lane 0 in LSBs
module operand_bank_ram
  import operand_bank_pkg::*;
#(
  parameter  int DATA_W  = 4,
  parameter  int DIM_MAX = 3,
  localparam int DIM_W   = dimWidth(DIM_MAX),
  localparam int CNT_W   = cntWidth(DIM_MAX)
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [CNT_W-1:0]          waddr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  input  logic [CNT_W-1:0]          base_i,
  input  logic [DIM_W-1:0]          stride_i,
  input  logic [DIM_W-1:0]          count_i,
  output logic [DIM_MAX*DATA_W-1:0] rdata_o
);

  localparam int DEPTH = DIM_MAX * DIM_MAX;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; the controller never streams
  // contents that were not written by a completed load.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Inactive lanes are masked so the MAC array sees zeros outside the
  // active dimensions. Active addresses never exceed DEPTH-1.
  always_comb begin
    rdata_o = '0;
    for (int lane = 0; lane < DIM_MAX; lane++) begin
      if (DIM_W'(lane) < count_i) begin
        rdata_o[lane*DATA_W +: DATA_W] =
          mem_q[CNT_W'(lane) * CNT_W'(stride_i) + base_i];
      end
    end
  end

endmodule

// File: rtl/operand_bank.sv
// operand_bank
//   Operand store for a DIM_MAX x DIM_MAX outer-product MAC array.
//   Loads W (row_w x col_w) then X (col_w x col_x) row-major over a
//   valid/ready port, then streams one k-step per beat: column k of W on
//   data_outw and row k of X on data_outx, with per-cell ld_mac enables.
//   Pulses unload_res for one cycle once the last beat has been consumed.
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-high reset
//     bus   operand_bank_if.slave (control, load port, stream port, status)
//   Configuration:
//     OPERAND_BANK_BACKPRESSURE_EN  adds bus.mac_ready; a beat is consumed
//     only on out_valid & mac_ready, and ld_mac is gated by mac_ready.
module operand_bank
  import operand_bank_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int DIM_MAX = 3
) (
  input logic          clk,
  input logic          rst,
  operand_bank_if.slave bus
);

  localparam int DIM_W  = dimWidth(DIM_MAX);
  localparam int CNT_W  = cntWidth(DIM_MAX);
  localparam int PROD_W = 2 * DIM_W;

  state_e           state_q;
  logic [DIM_W-1:0] rowW_q, colW_q, colX_q;
  logic [DIM_W-1:0] k_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             clear_q;

  logic                       dimsOk_d;
  logic                       loading_d;
  logic                       stream_d;
  logic                       xfer_d;
  logic                       beat_d;
  logic                       wLast_d, xLast_d, kLast_d;
  logic [PROD_W-1:0]          wTotal_d, xTotal_d;
  logic [CNT_W-1:0]           xBase_d;
  logic [DIM_MAX*DATA_W-1:0]  wRd_d, xRd_d;
  logic [DIM_MAX*DIM_MAX-1:0] ldMask_d;

  // Decode of the current state plus the end-of-phase comparisons.
  // Element counts are compared as "index == total-1" so the counter never
  // has to hold the full DIM_MAX^2 value.
  always_comb begin
    dimsOk_d  = (bus.row_w != '0) && (bus.row_w <= DIM_W'(DIM_MAX)) &&
                (bus.col_w != '0) && (bus.col_w <= DIM_W'(DIM_MAX)) &&
                (bus.col_x != '0) && (bus.col_x <= DIM_W'(DIM_MAX));
    loading_d = (state_q == ST_LOAD_W) || (state_q == ST_LOAD_X);
    stream_d  = (state_q == ST_STREAM);
    xfer_d    = bus.in_valid && loading_d;
`ifdef OPERAND_BANK_BACKPRESSURE_EN
    beat_d    = stream_d && bus.mac_ready;
`else
    beat_d    = stream_d;
`endif
    wTotal_d  = PROD_W'(rowW_q) * PROD_W'(colW_q);
    xTotal_d  = PROD_W'(colW_q) * PROD_W'(colX_q);
    wLast_d   = (PROD_W'(cnt_q) == wTotal_d - PROD_W'(1));
    xLast_d   = (PROD_W'(cnt_q) == xTotal_d - PROD_W'(1));
    kLast_d   = (k_q == colW_q - DIM_W'(1));
    xBase_d   = CNT_W'(k_q) * CNT_W'(colX_q);
  end

  // Controller: dimension latch, load counter and k-step counter.
  // Loads write at the running flat index, which is exactly the row-major
  // index because elements arrive in row-major order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rowW_q  <= '0;
      colW_q  <= '0;
      colX_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      err_q   <= 1'b0;
      clear_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (dimsOk_d) begin
              rowW_q  <= bus.row_w;
              colW_q  <= bus.col_w;
              colX_q  <= bus.col_x;
              cnt_q   <= '0;
              k_q     <= '0;
              clear_q <= 1'b1;
              state_q <= ST_LOAD_W;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_LOAD_W: begin
          if (xfer_d) begin
            if (wLast_d) begin
              cnt_q   <= '0;
              state_q <= ST_LOAD_X;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_LOAD_X: begin
          if (xfer_d) begin
            if (xLast_d) begin
              cnt_q   <= '0;
              k_q     <= '0;
              state_q <= ST_STREAM;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_STREAM: begin
          if (beat_d) begin
            if (kLast_d) begin
              k_q     <= '0;
              state_q <= ST_DONE;
            end else begin
              k_q <= k_q + DIM_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // W is read down a column: lane i sits at i*col_w + k.
  operand_bank_ram #(.DATA_W(DATA_W), .DIM_MAX(DIM_MAX)) uRamW (
    .clk      (clk),
    .we_i     (xfer_d && (state_q == ST_LOAD_W)),
    .waddr_i  (cnt_q),
    .wdata_i  (bus.in_data),
    .base_i   (CNT_W'(k_q)),
    .stride_i (colW_q),
    .count_i  (rowW_q),
    .rdata_o  (wRd_d)
  );

  // X is read along a row: lane j sits at k*col_x + j.
  operand_bank_ram #(.DATA_W(DATA_W), .DIM_MAX(DIM_MAX)) uRamX (
    .clk      (clk),
    .we_i     (xfer_d && (state_q == ST_LOAD_X)),
    .waddr_i  (cnt_q),
    .wdata_i  (bus.in_data),
    .base_i   (xBase_d),
    .stride_i (DIM_W'(1)),
    .count_i  (colX_q),
    .rdata_o  (xRd_d)
  );

  // Cell (i,j) loads only on a consumed beat inside the active M x N block.
  always_comb begin
    ldMask_d = '0;
    for (int i = 0; i < DIM_MAX; i++) begin
      for (int j = 0; j < DIM_MAX; j++) begin
        if (beat_d && (DIM_W'(i) < rowW_q) && (DIM_W'(j) < colX_q)) begin
          ldMask_d[i*DIM_MAX + j] = 1'b1;
        end
      end
    end
  end

  // Status outputs decode directly from registered state, so they are all
  // zero as soon as reset asserts and data lanes stay zero outside STREAM.
  assign bus.in_ready   = loading_d;
  assign bus.out_valid  = stream_d;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.unload_res = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.clear_mac  = {(DIM_MAX*DIM_MAX){clear_q}};
  assign bus.ld_mac     = ldMask_d;
  assign bus.data_outw  = stream_d ? wRd_d : '0;
  assign bus.data_outx  = stream_d ? xRd_d : '0;

endmodule

// File: tb/tb_operand_bank.sv
// tb_operand_bank
//   Self-checking bench for operand_bank (DATA_W=4, DIM_MAX=3).
//   Expected stream beats are queued when a product is set up and checked
//   as the bank emits them. Also exercises OPERAND_BANK_BACKPRESSURE_EN
//   when that macro is defined.
module tb_operand_bank;

  localparam int DW   = 4;
  localparam int D    = 3;
  localparam int N    = D * D;
  localparam int DIMW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic macReady = 1'b1;

  operand_bank_if #(.DATA_W(DW), .DIM_MAX(D)) bus ();

  operand_bank #(.DATA_W(DW), .DIM_MAX(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef OPERAND_BANK_BACKPRESSURE_EN
  assign bus.mac_ready = macReady;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [D*DW-1:0] w;
    logic [D*DW-1:0] x;
    logic [N-1:0]    ld;
  } beat_t;

  beat_t expQ[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    monEn    = 1'b0;
  int    wMem[N];
  int    xMem[N];

  // Cycle index, used to measure unload latency
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every streamed beat must match the head of the queue;
  // a stalled beat must hold its data with ld_mac low.
  always @(negedge clk) begin
    if (monEn && !rst) begin
      if (bus.out_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("extra_beat", 32'd1, 32'd0);
        end else begin
          checkOutput("beat_w", 32'(bus.data_outw), 32'(expQ[0].w));
          checkOutput("beat_x", 32'(bus.data_outx), 32'(expQ[0].x));
          if (macReady) begin
            checkOutput("beat_ld", 32'(bus.ld_mac), 32'(expQ[0].ld));
            void'(expQ.pop_front());
          end else begin
            checkOutput("stall_ld", 32'(bus.ld_mac), 32'd0);
          end
        end
      end else begin
        checkOutput("idle_ld", 32'(bus.ld_mac), 32'd0);
      end
    end
  end

  // Issue a legal start and confirm the bank entered loading
  task automatic startOp(input int r, input int k, input int n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.row_w = DIMW'(r);
    bus.col_w = DIMW'(k);
    bus.col_x = DIMW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("clear_mac", 32'(bus.clear_mac), 32'h1FF);
    checkOutput("busy_load", 32'(bus.busy), 32'd1);
    checkOutput("ready_load", 32'(bus.in_ready), 32'd1);
  endtask

  // Present one element for one cycle, optionally followed by an idle cycle
  task automatic applyStimulus(input logic [DW-1:0] d, input bit gap);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Full product: queue expected beats, load W and X from wMem/xMem,
  // optionally check beat 0 against constants, optionally stall, then
  // check unload timing and that every beat was seen.
  task automatic runProduct(input int r, input int k, input int n,
                            input bit gaps, input bit chkFirst,
                            input logic [D*DW-1:0] firstW,
                            input logic [D*DW-1:0] firstX,
                            input logic [N-1:0] firstLd,
                            input int stallBeat);
    beat_t b;
    int    xCyc;
    int    stallCyc;
    bit    found;
    stallCyc = 0;
    xCyc     = 0;
    for (int kk = 0; kk < k; kk++) begin
      b.w  = '0;
      b.x  = '0;
      b.ld = '0;
      for (int i = 0; i < r; i++) b.w[i*DW +: DW] = wMem[i*k + kk][DW-1:0];
      for (int j = 0; j < n; j++) b.x[j*DW +: DW] = xMem[kk*n + j][DW-1:0];
      for (int i = 0; i < r; i++)
        for (int j = 0; j < n; j++) b.ld[i*D + j] = 1'b1;
      expQ.push_back(b);
    end
    startOp(r, k, n);
    for (int e = 0; e < r*k; e++) applyStimulus(wMem[e][DW-1:0], gaps);
    for (int e = 0; e < k*n; e++) begin
      if (e == k*n - 1) xCyc = cyc;
      applyStimulus(xMem[e][DW-1:0], gaps && (e != k*n - 1));
    end
    if (chkFirst) begin
      @(negedge clk);
      checkOutput("first_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("first_w", 32'(bus.data_outw), 32'(firstW));
      checkOutput("first_x", 32'(bus.data_outx), 32'(firstX));
      checkOutput("first_ld", 32'(bus.ld_mac), 32'(firstLd));
    end
`ifdef OPERAND_BANK_BACKPRESSURE_EN
    if (stallBeat >= 0) begin
      repeat (stallBeat) @(posedge clk);
      #1 macReady = 1'b0;
      repeat (2) @(posedge clk);
      #1 macReady = 1'b1;
      stallCyc = 2;
    end
`endif
    found = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.unload_res === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (found) checkOutput("unload_lat", cyc - xCyc, k + 1 + stallCyc);
    else       checkOutput("unload_timeout", 32'd0, 32'd1);
    @(negedge clk);
    checkOutput("unload_pulse", 32'(bus.unload_res), 32'd0);
    checkOutput("busy_done", 32'(bus.busy), 32'd0);
    checkOutput("beats_left", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.row_w    = '0;
    bus.col_w    = '0;
    bus.col_x    = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset values
    #2 rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_unload", 32'(bus.unload_res), 32'd0);
    checkOutput("rst_err", 32'(bus.err), 32'd0);
    checkOutput("rst_ld_mac", 32'(bus.ld_mac), 32'd0);
    checkOutput("rst_clear_mac", 32'(bus.clear_mac), 32'd0);
    checkOutput("rst_outw", 32'(bus.data_outw), 32'd0);
    checkOutput("rst_outx", 32'(bus.data_outx), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    monEn = 1'b1;

    // 3x3x3 with W = X = 1..9
    for (int e = 0; e < N; e++) begin
      wMem[e] = e + 1;
      xMem[e] = e + 1;
    end
    runProduct(3, 3, 3, 1'b0, 1'b1, {4'd7, 4'd4, 4'd1}, {4'd3, 4'd2, 4'd1},
               9'h1FF, -1);

    // 2x3x1: W = 1..6, X = 10,11,12
    for (int e = 0; e < 6; e++) wMem[e] = e + 1;
    for (int e = 0; e < 3; e++) xMem[e] = e + 10;
    runProduct(2, 3, 1, 1'b0, 1'b1, {4'd0, 4'd4, 4'd1}, {4'd0, 4'd0, 4'd10},
               9'b000_001_001, -1);

    // Illegal start (col_w = 0)
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.row_w = DIMW'(1);
    bus.col_w = DIMW'(0);
    bus.col_x = DIMW'(1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("err_pulse", 32'(bus.err), 32'd1);
    checkOutput("err_busy", 32'(bus.busy), 32'd0);
    checkOutput("err_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("err_no_clear", 32'(bus.clear_mac), 32'd0);
    @(posedge clk); #1;
    checkOutput("err_one_cycle", 32'(bus.err), 32'd0);
    checkOutput("err_idle", 32'(bus.busy), 32'd0);

    // 1x1x1 with in_valid 1-0-1
    wMem[0] = 5;
    xMem[0] = 9;
    runProduct(1, 1, 1, 1'b1, 1'b1, {8'd0, 4'd5}, {8'd0, 4'd9}, 9'h001, -1);

    // Reset during LOAD_X, then a start without reload
    startOp(2, 2, 2);
    for (int e = 0; e < 4; e++) applyStimulus(DW'(e + 1), 1'b0);
    applyStimulus(4'd6, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 4'd7;
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_ld_mac", 32'(bus.ld_mac), 32'd0);
    checkOutput("abort_outw", 32'(bus.data_outw), 32'd0);
    checkOutput("abort_outx", 32'(bus.data_outx), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    expQ.delete();
    startOp(2, 2, 2);
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_stale_beat", 32'(bus.out_valid), 32'd0);
    end
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Random shapes and data
    for (int it = 0; it < 3; it++) begin
      int r, k, n;
      r = int'($urandom_range(1, 3));
      k = int'($urandom_range(1, 3));
      n = int'($urandom_range(1, 3));
      for (int e = 0; e < N; e++) begin
        wMem[e] = int'($urandom_range(0, 15));
        xMem[e] = int'($urandom_range(0, 15));
      end
      runProduct(r, k, n, bit'($urandom_range(0, 1)), 1'b0, '0, '0, '0, -1);
    end

`ifdef OPERAND_BANK_BACKPRESSURE_EN
    // 3x3x3 with beat 1 stalled for two cycles
    for (int e = 0; e < N; e++) begin
      wMem[e] = e + 1;
      xMem[e] = e + 1;
    end
    runProduct(3, 3, 3, 1'b0, 1'b0, '0, '0, '0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
